decoder_2_4: RTL and testbench
==============================

// Module: decoder_2_4
// PURPOSE
//  - 2-to-4 one-hot decoder with enable; leaf block of the register-file write-select decode tree.
//  - Two instances plus one decoder_1_2 form the 3-to-8 decoder.
//  - Provides a combinational one-hot output and a one-cycle registered copy for pipelined consumers.
// PARAMETERS
//  - none (widths fixed: in = 2 bits, out = 4 bits; constants live in decode_pkg)
// PORTS
//  - clk      input   1  single clock; all state updates on rising edge
//  - reset    input   1  synchronous, active-high reset
//  - en       input   1  decode enable; 0 forces all outputs low
//  - in       input   2  binary select index
//  - out      output  4  combinational one-hot decode of in, gated by en
//  - out_q    output  4  out registered on clk
//  - valid_q  output  1  registered en (marks out_q as a live decode)
//  - onehot_err output 1 present only with DECODE_ONEHOT_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Combinational: out[i] = en & (in == i), for i = 0..3.
//    - en = 0 -> out = 4'b0000 regardless of in.
//    - en = 1 -> exactly one bit set.
//  - Decode is built hierarchically:
//    - decoder_1_2 on in[1] with en produces group enables g[1:0].
//    - Each g[k] enables a 1-to-2 decode of in[0] into out[2k+1:2k].
//    - Result must be bit-identical to the flat equation above.
//  - decoder_1_2 function: out[0] = en & ~in, out[1] = en & in.
//  - Registered path:
//    - On each rising clk: out_q <= out and valid_q <= en.
//    - Latency is exactly 1 cycle; no handshake and no stall.
//  - Reset:
//    - reset = 1 at a clock edge -> out_q = 4'b0000, valid_q = 0 on that edge.
//    - Reset has priority over en and in.
//    - Combinational out is NOT affected by reset; it still follows en/in.
//  - Reset mid-stream: the decode captured at the reset edge is discarded. The first capture after reset deasserts is the next edge.
//  - Invariants:
//    - out_q is always zero or one-hot.
//    - valid_q = 0 implies out_q = 4'b0000.
//  - No internal state other than out_q and valid_q; no FSM.
// CONFIGURATION
//  - Macro DECODE_ONEHOT_CHECK_EN.
//    - Defined: adds port onehot_err (1 bit, registered). Each edge, onehot_err <= 1 iff out has more than one bit set, or en = 1 with out = 0. Reset clears it to 0. Also adds an immediate assertion on the same condition for simulation.
//    - Undefined: onehot_err port and checker are absent; all other behaviour is unchanged.
// STRUCTURE
//  - decode_pkg:
//    - DEC_SEL_W = 2 and DEC_OUT_W = 4.
//    - typedef logic [DEC_SEL_W-1:0] dec_sel_t.
//    - typedef logic [DEC_OUT_W-1:0] dec_onehot_t.
//    - function is_onehot0() shared by the checker and the bench.
//  - Sub-module decoder_1_2 (in, en -> out[1:0]) is instantiated three times: one group select on in[1], two leaf decodes on in[0].
//  - Output register stage is kept in this module, not in the sub-module.
// TESTING
//  - en=0, in=2'b00..2'b11 swept -> out=4'b0000 each step; next edge out_q=4'b0000, valid_q=0.
//  - en=1, in=00,01,10,11 in sequence -> out=0001,0010,0100,1000. out_q follows one cycle later, with valid_q=1.
//  - reset=1 held 2 cycles with en=1, in=2'b10 -> out=4'b0100 combinationally; out_q=0000 and valid_q=0 throughout. First edge after release gives out_q=0100.
//  - Toggle en 1->0 with in=2'b11 -> out drops to 0000 immediately; out_q goes 1000 -> 0000 on the next edge.
//  - Exhaustive en x in (8 combos) against is_onehot0() and the flat equation -> zero mismatches.
//  - With DECODE_ONEHOT_CHECK_EN, legal traffic -> onehot_err stays 0. Forcing the internal group enable to 2'b11 -> onehot_err=1 one cycle later.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared widths, types and the one-hot helper for the write-select decode tree.
// The optional checker in decoder_2_4 is enabled by DECODE_ONEHOT_CHECK_EN.
package decode_pkg;

   localparam int unsigned DEC_SEL_W = 2;
   localparam int unsigned DEC_OUT_W = 4;

   typedef logic [DEC_SEL_W-1:0] dec_sel_t;
   typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

   // True when v is all-zero or has exactly one bit set.
   function automatic logic is_onehot0(input dec_onehot_t v);
      return (v & (v - dec_onehot_t'(1))) == dec_onehot_t'(0);
   endfunction

endpackage : decode_pkg

// File: rtl/decoder_1_2.sv
// 1-to-2 decoder with enable; building block of the 2-to-4 decode tree.
module decoder_1_2 (
   input  logic       en,
   input  logic       in,
   output logic [1:0] out
);

   assign out[0] = en & ~in;
   assign out[1] = en &  in;

endmodule : decoder_1_2

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder with enable, combinational output plus a 1-cycle registered copy.
// Define DECODE_ONEHOT_CHECK_EN to add the registered onehot_err checker port.
module decoder_2_4
   import decode_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  dec_sel_t    in,
   output dec_onehot_t out,
   output dec_onehot_t out_q,
   output logic        valid_q
`ifdef DECODE_ONEHOT_CHECK_EN
   ,
   output logic        onehot_err
`endif
);

   logic [1:0]  grp_en;
   dec_onehot_t out_d;
   logic        valid_d;

   // in[1] picks the half, in[0] picks the bit within it.
   decoder_1_2 u_grp (
      .en  (en),
      .in  (in[1]),
      .out (grp_en)
   );

   decoder_1_2 u_lo (
      .en  (grp_en[0]),
      .in  (in[0]),
      .out (out[1:0])
   );

   decoder_1_2 u_hi (
      .en  (grp_en[1]),
      .in  (in[0]),
      .out (out[3:2])
   );

   always_comb begin
      out_d   = out;
      valid_d = en;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q   <= dec_onehot_t'(0);
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

`ifdef DECODE_ONEHOT_CHECK_EN
   logic err_d;

   // Flag more than one bit set, or an enabled decode that produced nothing.
   always_comb begin
      err_d = !is_onehot0(out) || (en && (out == dec_onehot_t'(0)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         onehot_err <= 1'b0;
      end else begin
         onehot_err <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!err_d)
            else $error("decoder_2_4: illegal decode en=%b in=%b out=%b", en, in, out);
      end
   end
`endif

endmodule : decoder_2_4

// File: tb/tb_decoder_2_4.sv
// Directed bench for decoder_2_4: flat-equation model for out, scoreboard queue for out_q/valid_q.
// Also checks onehot_err when built with DECODE_ONEHOT_CHECK_EN.
module tb_decoder_2_4;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   dec_sel_t    in;
   dec_onehot_t out;
   dec_onehot_t out_q;
   logic        valid_q;
`ifdef DECODE_ONEHOT_CHECK_EN
   logic        onehot_err;
`endif

   int unsigned n_vec  = 0;
   int unsigned n_chk  = 0;
   int unsigned n_err  = 0;

   typedef struct packed {
      dec_onehot_t q;
      logic        v;
      logic        rst;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   decoder_2_4 dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .in      (in),
      .out     (out),
      .out_q   (out_q),
      .valid_q (valid_q)
`ifdef DECODE_ONEHOT_CHECK_EN
      ,
      .onehot_err (onehot_err)
`endif
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
         end
   endtask

   function automatic dec_onehot_t model(input logic e, input dec_sel_t s);
      dec_onehot_t r;
      for (int i = 0; i < 4; i++) r[i] = e & (s == dec_sel_t'(i));
      return r;
   endfunction

   // Drive one vector, check the combinational path, then the registered path after the edge.
   task automatic step(input logic r, input logic e, input dec_sel_t s);
      exp_t   x;
      dec_onehot_t m;
      @(negedge clk);
      reset = r;
      en    = e;
      in    = s;
      n_vec++;
      #1;
      m = model(e, s);
      check("out", 8'(out), 8'(m));
      check("out_onehot0", 8'(is_onehot0(out)), 8'(1));
      x.q   = r ? dec_onehot_t'(0) : m;
      x.v   = r ? 1'b0 : e;
      x.rst = r;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_chk++;
         n_err++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         x = sb_q.pop_front();
         check("out_q", 8'(out_q), 8'(x.q));
         check("valid_q", 8'(valid_q), 8'(x.v));
         check("inv_valid_zero", 8'(valid_q || (out_q == dec_onehot_t'(0))), 8'(1));
`ifdef DECODE_ONEHOT_CHECK_EN
         check("onehot_err", 8'(onehot_err), 8'(0));
`endif
      end
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      in    = '0;

      // Reset held two cycles with a live decode on the inputs.
      step(1'b1, 1'b1, 2'b10);
      step(1'b1, 1'b1, 2'b10);
      step(1'b0, 1'b1, 2'b10);

      // Disabled sweep.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, dec_sel_t'(i));

      // Enabled sweep.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, dec_sel_t'(i));

      // Enable drop with in=11.
      step(1'b0, 1'b1, 2'b11);
      step(1'b0, 1'b0, 2'b11);

      // Reset mid-stream discards the capture at that edge.
      step(1'b0, 1'b1, 2'b01);
      step(1'b1, 1'b1, 2'b10);
      step(1'b0, 1'b1, 2'b11);

      // Exhaustive en x in.
      for (int i = 0; i < 8; i++) step(1'b0, i[2], dec_sel_t'(i));

      // Random traffic with occasional reset.
      for (int i = 0; i < 24; i++)
         step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              dec_sel_t'($urandom_range(0, 3)));

`ifdef DECODE_ONEHOT_CHECK_EN
      // Corrupt the group enables so two bits fire; checker must flag it next edge.
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      in    = 2'b00;
      force dut.grp_en = 2'b11;
      n_vec++;
      @(posedge clk);
      #1;
      check("onehot_err_forced", 8'(onehot_err), 8'(1));
      @(negedge clk);
      release dut.grp_en;
      step(1'b0, 1'b1, 2'b00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_decoder_2_4
